// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and float field helpers for the sequential ALU.
package alu_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 7;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_INVF = 4'h1;
  localparam logic [3:0] OP_ADDF = 4'h2;
  localparam logic [3:0] OP_MULF = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ANY  = 4'h7;
  localparam logic [3:0] OP_DUP  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_F2I  = 4'hA;
  localparam logic [3:0] OP_I2F  = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_EXEC   = 3'd2,
    ST_NORM   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Field slicers work on a zero-extended word so they serve any float geometry up to 32 bits.
  function automatic logic fp_sign(input logic [31:0] x, input int exp_w, input int man_w);
    return x[exp_w + man_w];
  endfunction

  function automatic logic [31:0] fp_exp(input logic [31:0] x, input int exp_w, input int man_w);
    return (x >> man_w) & ((32'd1 << exp_w) - 32'd1);
  endfunction

  function automatic logic [31:0] fp_man(input logic [31:0] x, input int man_w);
    return x & ((32'd1 << man_w) - 32'd1);
  endfunction

endpackage

// File: rtl/alu_seq_lzc.sv
// Combinational leading-zero count; an all-zero vector reports W.
module lead_zero_count import alu_pkg::*; #(
  parameter int W = 16
) (
  input  logic [W-1:0]             vec,
  output logic [$clog2(W+1)-1:0]   count
);
  localparam int CW = $clog2(W + 1);

  // Scan upward so the highest set bit is the last one to update the count
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      count = vec[i] ? CW'(W - 1 - i) : count;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: integer ops finish in one cycle, float ops run
// UNPACK -> EXEC -> NORM before the result is presented.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int MW   = MAN_W + 1;
  localparam int NV   = (WIDTH > 2*MW) ? WIDTH : 2*MW;
  localparam int XW   = EXP_W + 3;
  localparam int CW   = $clog2(NV + 1);
  localparam logic signed [XW-1:0] X_ZERO = XW'(0);
  localparam logic signed [XW-1:0] X_ONE  = XW'(1);
  localparam logic signed [XW-1:0] X_MAN  = XW'(MAN_W);
  localparam logic signed [XW-1:0] X_SAT  = XW'(WIDTH - 1);
  localparam logic signed [XW-1:0] X_EMAX = XW'(2**EXP_W - 1);

  state_t state_r;
  logic [3:0]       code_r;
  logic [WIDTH-1:0] a_r, b_r, dres_r;
  logic             sa_r, sb_r, direct_r, sg_r;
  logic [EXP_W-1:0] ea_r, eb_r;
  logic [MW-1:0]    ma_r, mb_r;
  logic [NV-1:0]    nv_r;
  logic signed [XW-1:0] ex_r;

  logic [WIDTH-1:0] int_res_s;
  logic             int_err_s, float_s;

  // One-cycle integer results and float dispatch, decoded straight off the input bus
  always_comb begin
    int_res_s = in1;
    int_err_s = 1'b0;
    float_s   = 1'b0;
    if (op[4]) begin
      int_res_s = in1;
    end else begin
      case (op[3:0])
        OP_ADD:  int_res_s = in1 + in2;
        OP_INVF: begin int_res_s = '0; int_err_s = 1'b1; end
        OP_AND:  int_res_s = in1 & in2;
        OP_OR:   int_res_s = in1 | in2;
        OP_XOR:  int_res_s = in1 ^ in2;
        OP_ANY:  int_res_s = {{(WIDTH-1){1'b0}}, |in1};
        OP_DUP:  int_res_s = in1;
        OP_SHR:  int_res_s = in1 >> 1'b1;
        OP_ADDF, OP_MULF, OP_F2I, OP_I2F: float_s = 1'b1;
        default: int_res_s = in1;
      endcase
    end
  end

  logic za_s, zb_s, ia_s, ib_s, a_big_s, sbig_s;
  logic [EXP_W-1:0] ediff_s, ebig_s;
  logic [MW-1:0]    mbig_s, msml_s, msml_sh_s;
  logic [MW:0]      sum_s;
  logic [2*MW-1:0]  prod_s;
  logic [WIDTH-1:0] abs_s, f2i_mag_s, x_dres_s;
  logic signed [XW-1:0] fe_s, x_ex_s;
  logic [NV-1:0]    x_nv_s;
  logic             x_direct_s, x_sg_s;

  assign za_s = (ea_r == '0);
  assign zb_s = (eb_r == '0);
  assign ia_s = &ea_r;
  assign ib_s = &eb_r;

  // EXEC: produce either a finished word or an (unnormalised value, exponent, sign) triple
  always_comb begin
    a_big_s   = (ea_r > eb_r) || ((ea_r == eb_r) && (ma_r >= mb_r));
    ediff_s   = a_big_s ? (ea_r - eb_r) : (eb_r - ea_r);
    ebig_s    = a_big_s ? ea_r : eb_r;
    sbig_s    = a_big_s ? sa_r : sb_r;
    mbig_s    = a_big_s ? ma_r : mb_r;
    msml_s    = a_big_s ? mb_r : ma_r;
    msml_sh_s = (ediff_s >= EXP_W'(MW)) ? '0 : (msml_s >> ediff_s);
    sum_s     = (sa_r == sb_r) ? ({1'b0, mbig_s} + {1'b0, msml_sh_s})
                               : ({1'b0, mbig_s} - {1'b0, msml_sh_s});
    prod_s    = {{MW{1'b0}}, ma_r} * {{MW{1'b0}}, mb_r};
    abs_s     = a_r[WIDTH-1] ? (~a_r + WIDTH'(1)) : a_r;
    fe_s      = XW'(ea_r) - XW'(BIAS);
    f2i_mag_s = (fe_s >= X_MAN) ? (WIDTH'(ma_r) << (fe_s - X_MAN))
                                : (WIDTH'(ma_r) >> (X_MAN - fe_s));
    x_direct_s = 1'b0;
    x_dres_s   = '0;
    x_nv_s     = '0;
    x_ex_s     = X_ZERO;
    x_sg_s     = 1'b0;
    case (code_r)
      OP_ADDF: begin
        if (za_s)      begin x_direct_s = 1'b1; x_dres_s = b_r; end
        else if (zb_s) begin x_direct_s = 1'b1; x_dres_s = a_r; end
        else if (ia_s) begin x_direct_s = 1'b1; x_dres_s = a_r; end
        else if (ib_s) begin x_direct_s = 1'b1; x_dres_s = b_r; end
        else begin
          x_nv_s = NV'(sum_s) << (NV - MW - 1);
          x_ex_s = XW'(ebig_s) + X_ONE;
          x_sg_s = sbig_s;
        end
      end
      OP_MULF: begin
        x_sg_s = sa_r ^ sb_r;
        if (za_s || zb_s) begin
          x_direct_s = 1'b1;
          x_dres_s   = {x_sg_s, {(WIDTH-1){1'b0}}};
        end else if (ia_s || ib_s) begin
          x_direct_s = 1'b1;
          x_dres_s   = {x_sg_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
          x_nv_s = NV'(prod_s) << (NV - 2*MW);
          x_ex_s = XW'(ea_r) + XW'(eb_r) - XW'(BIAS) + X_ONE;
        end
      end
      OP_I2F: begin
        x_nv_s = NV'(abs_s);
        x_ex_s = XW'(BIAS + NV - 1);
        x_sg_s = a_r[WIDTH-1];
      end
      OP_F2I: begin
        x_direct_s = 1'b1;
        if (fe_s >= X_SAT) begin
          x_dres_s = sa_r ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else if (fe_s < X_ZERO) begin
          x_dres_s = '0;
        end else begin
          x_dres_s = sa_r ? (~f2i_mag_s + WIDTH'(1)) : f2i_mag_s;
        end
      end
      default: begin
        x_direct_s = 1'b1;
        x_dres_s   = '0;
      end
    endcase
  end

  logic [CW-1:0]    lz_s;
  logic [NV-1:0]    norm_sh_s;
  logic signed [XW-1:0] fexp_s;
  logic [MAN_W-1:0] man_s;
  logic [WIDTH-1:0] norm_res_s;

  lead_zero_count #(.W(NV)) u_lzc (
    .vec   (nv_r),
    .count (lz_s)
  );

  // NORM: left-justify, rebuild the exponent and clamp to zero/inf
  always_comb begin
    norm_sh_s = nv_r << lz_s;
    fexp_s    = ex_r - XW'(lz_s);
    man_s     = MAN_W'(norm_sh_s >> (NV - 1 - MAN_W));
    if (direct_r) begin
      norm_res_s = dres_r;
    end else if (nv_r == '0) begin
      norm_res_s = '0;
    end else if (fexp_s >= X_EMAX) begin
      norm_res_s = {sg_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (fexp_s < X_ONE) begin
      norm_res_s = {sg_r, {(WIDTH-1){1'b0}}};
    end else begin
      norm_res_s = {sg_r, fexp_s[EXP_W-1:0], man_s};
    end
  end

  // Control FSM with the pipeline registers and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
      code_r    <= OP_ADD;
      a_r <= '0; b_r <= '0; dres_r <= '0;
      sa_r <= 1'b0; sb_r <= 1'b0; direct_r <= 1'b0; sg_r <= 1'b0;
      ea_r <= '0; eb_r <= '0; ma_r <= '0; mb_r <= '0;
      nv_r <= '0; ex_r <= X_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in1;
            b_r      <= in2;
            code_r   <= op[3:0];
            in_ready <= 1'b0;
            if (float_s) begin
              state_r <= ST_UNPACK;
            end else begin
              result    <= int_res_s;
              err       <= int_err_s;
              out_valid <= 1'b1;
              state_r   <= ST_DONE;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_UNPACK: begin
          sa_r    <= fp_sign(32'(a_r), EXP_W, MAN_W);
          sb_r    <= fp_sign(32'(b_r), EXP_W, MAN_W);
          ea_r    <= EXP_W'(fp_exp(32'(a_r), EXP_W, MAN_W));
          eb_r    <= EXP_W'(fp_exp(32'(b_r), EXP_W, MAN_W));
          ma_r    <= {1'b1, MAN_W'(fp_man(32'(a_r), MAN_W))};
          mb_r    <= {1'b1, MAN_W'(fp_man(32'(b_r), MAN_W))};
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          direct_r <= x_direct_s;
          dres_r   <= x_dres_s;
          nv_r     <= x_nv_s;
          ex_r     <= x_ex_s;
          sg_r     <= x_sg_s;
          state_r  <= ST_NORM;
        end
        ST_NORM: begin
          result    <= norm_res_s;
          err       <= 1'b0;
          out_valid <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (16-bit word, 8-bit exponent, 7-bit mantissa).
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [15:0] in1, in2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int seen;

  alu_seq #(.WIDTH(16), .EXP_W(8), .MAN_W(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [4:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_res, input logic exp_err,
                       input int exp_lat, input int hold);
    int w;
    int lat;
    w = 0;
    lat = 1;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, " ready"}, 16'(in_ready), 16'd1);
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'h01; in1 = ~a; in2 = ~b;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " lat"}, 16'(lat), 16'(exp_lat));
    check({tag, " res"}, result, exp_res);
    check({tag, " err"}, 16'(err), 16'(exp_err));
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      check({tag, " held res"}, result, exp_res);
      check({tag, " held rdy"}, 16'(in_ready), 16'd0);
      check({tag, " held vld"}, 16'(out_valid), 16'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " done"}, 16'(out_valid), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 5'h00; in1 = 16'h0000; in2 = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 16'(in_ready), 16'd0);
    check("rst out_valid", 16'(out_valid), 16'd0);
    check("rst result", result, 16'h0000);
    check("rst err", 16'(err), 16'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post-rst in_ready", 16'(in_ready), 16'd1);

    // integer and default ops
    do_op("add wrap", 5'h00, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1, 0);
    do_op("and",      5'h04, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1, 0);
    do_op("or",       5'h05, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1, 0);
    do_op("any one",  5'h07, 16'h0100, 16'h0000, 16'h0001, 1'b0, 1, 0);
    do_op("any zero", 5'h07, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1, 0);
    do_op("shr",      5'h09, 16'h8001, 16'h0000, 16'h4000, 1'b0, 1, 0);
    do_op("dup",      5'h08, 16'h1234, 16'h5678, 16'h1234, 1'b0, 1, 0);
    do_op("dflt 0E",  5'h0E, 16'hABCD, 16'h1111, 16'hABCD, 1'b0, 1, 0);
    do_op("dflt 10",  5'h10, 16'hABCD, 16'h1111, 16'hABCD, 1'b0, 1, 0);
    do_op("invf",     5'h01, 16'h4040, 16'h4040, 16'h0000, 1'b1, 1, 0);

    // float conversions and arithmetic
    do_op("i2f 3",     5'h0B, 16'h0003, 16'h0000, 16'h4040, 1'b0, 4, 0);
    do_op("i2f -1",    5'h0B, 16'hFFFF, 16'h0000, 16'hBF80, 1'b0, 4, 0);
    do_op("i2f 0",     5'h0B, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4, 0);
    do_op("i2f min",   5'h0B, 16'h8000, 16'h0000, 16'hC700, 1'b0, 4, 0);
    do_op("f2i 3",     5'h0A, 16'h4040, 16'h0000, 16'h0003, 1'b0, 4, 0);
    do_op("f2i -6",    5'h0A, 16'hC0C0, 16'h0000, 16'hFFFA, 1'b0, 4, 0);
    do_op("f2i sat+",  5'h0A, 16'h4780, 16'h0000, 16'h7FFF, 1'b0, 4, 0);
    do_op("f2i sat-",  5'h0A, 16'hC780, 16'h0000, 16'h8000, 1'b0, 4, 0);
    do_op("f2i half",  5'h0A, 16'h3F00, 16'h0000, 16'h0000, 1'b0, 4, 0);
    do_op("mulf 2x3",  5'h03, 16'h4000, 16'h4040, 16'h40C0, 1'b0, 4, 0);
    do_op("mulf zero", 5'h03, 16'h0000, 16'hC040, 16'h8000, 1'b0, 4, 0);
    do_op("mulf ovf",  5'h03, 16'h7F00, 16'h7F00, 16'h7F80, 1'b0, 4, 0);
    do_op("addf 1+1",  5'h02, 16'h3F80, 16'h3F80, 16'h4000, 1'b0, 4, 0);
    do_op("addf 3-3",  5'h02, 16'h4040, 16'hC040, 16'h0000, 1'b0, 4, 0);
    do_op("addf 3+1",  5'h02, 16'h4040, 16'h3F80, 16'h4080, 1'b0, 4, 0);
    do_op("addf 0+3",  5'h02, 16'h0000, 16'h4040, 16'h4040, 1'b0, 4, 0);

    // consumer stall
    do_op("stall xor", 5'h06, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1, 5);

    // reset while a mulf sits in EXEC
    in_valid = 1'b1; op = 5'h03; in1 = 16'h4000; in2 = 16'h4040;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid-rst vld", 16'(out_valid), 16'd0);
    check("mid-rst rdy", 16'(in_ready), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("mid-rst no vld", 16'(seen), 16'd0);
    do_op("add after rst", 5'h00, 16'h0007, 16'h0001, 16'h0008, 1'b0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
